// File: rtl/cycle_counter_if.sv
// Handshake and data bundle between a control unit and cycle_counter.
// The master side drives start/stop/enable and the run parameters; the slave side reports count and status.
interface cycle_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             enable;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cont;
    logic             rco;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, enable, mode, dir, limit,
        input  cont, rco, busy, done
    );

    modport slave (
        input  start, stop, enable, mode, dir, limit,
        output cont, rco, busy, done
    );
endinterface

// File: rtl/cycle_counter.sv
// Modulo / one-shot cycle counter with start/stop/busy/done handshake for multi-cycle control sequencing.
// Define CYCLE_COUNTER_DOWN_EN to honour the dir input (down-counting from limit); otherwise up-count only.
module cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    cycle_counter_if.slave cc
);

    // state  | meaning
    // S_IDLE | stopped, cont holds last value
    // S_RUN  | counting on enabled cycles, busy high
    // S_DONE | one-shot finished, done high until start/stop
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cont_q, cont_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             rco_q, rco_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dir_q;

    logic             state_legal;
    logic             start_ok;
    logic             at_term;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

`ifdef CYCLE_COUNTER_DOWN_EN
    logic dir_d;

    always_comb begin
        dir_d = dir_q;
        if (start_ok) begin
            dir_d = cc.dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign step_val = dir_q ? (cont_q - WIDTH'(1)) : (cont_q + WIDTH'(1));
    assign load_val = cc.dir ? cc.limit : {WIDTH{1'b0}};
`else
    logic dir_unused;

    assign dir_unused = cc.dir;
    assign dir_q      = 1'b0;
    assign step_val   = cont_q + WIDTH'(1);
    assign load_val   = {WIDTH{1'b0}};
`endif

    assign state_legal = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
    assign start_ok    = cc.start && !cc.stop && state_legal;
    assign at_term     = (cont_q == (dir_q ? {WIDTH{1'b0}} : limit_q));
    assign reload_val  = dir_q ? limit_q : {WIDTH{1'b0}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cc.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cc.start) begin
                    state_d = S_RUN;
                end else if (cc.enable && at_term && mode_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (cc.stop) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cont_d  = cont_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        rco_d   = 1'b0;
        done_d  = done_q;
        if (cc.stop || !state_legal) begin
            done_d = 1'b0;
        end else if (start_ok) begin
            limit_d = cc.limit;
            mode_d  = cc.mode;
            cont_d  = load_val;
            done_d  = 1'b0;
        end else if (state_q == S_RUN && cc.enable) begin
            if (at_term) begin
                cont_d = reload_val;
                rco_d  = 1'b1;
                if (mode_q) begin
                    done_d = 1'b1;
                end
            end else begin
                cont_d = step_val;
            end
        end
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q  <= {WIDTH{1'b0}};
            limit_q <= {WIDTH{1'b0}};
            mode_q  <= 1'b0;
            rco_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cont_q  <= cont_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            rco_q   <= rco_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cc.cont = cont_q;
    assign cc.rco  = rco_q;
    assign cc.busy = busy_q;
    assign cc.done = done_q;

endmodule

// File: tb/tb_cycle_counter.sv
// Scoreboard bench for cycle_counter: expectations are queued as each cycle's stimulus is driven
// and popped for comparison once the edge has been taken.
module tb_cycle_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cycle_counter_if #(.WIDTH(W)) cc_if ();

    cycle_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .cc  (cc_if)
    );

    typedef struct {
        logic [W-1:0] cont;
        logic         rco;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state for the randomised segment
    int           m_state;
    logic [W-1:0] m_cont;
    logic [W-1:0] m_lim;
    logic         m_mode;
    logic         m_dir;
    logic         m_rco;
    logic         m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic st, input logic sp, input logic en,
                       input logic [W-1:0] e_cont, input logic e_rco, input logic e_busy,
                       input logic e_done);
        exp_t e;
        exp_t o;
        cc_if.start  = st;
        cc_if.stop   = sp;
        cc_if.enable = en;
        e.cont = e_cont;
        e.rco  = e_rco;
        e.busy = e_busy;
        e.done = e_done;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(1), 32'(0));
        end else begin
            o = sb_q.pop_front();
            check({tag, ".cont"}, 32'(cc_if.cont), 32'(o.cont));
            check({tag, ".rco"},  32'(cc_if.rco),  32'(o.rco));
            check({tag, ".busy"}, 32'(cc_if.busy), 32'(o.busy));
            check({tag, ".done"}, 32'(cc_if.done), 32'(o.done));
        end
        cc_if.start = 1'b0;
        cc_if.stop  = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic en);
        m_rco = 1'b0;
        if (sp) begin
            m_state = 0;
            m_done  = 1'b0;
        end else if (st) begin
            m_lim  = cc_if.limit;
            m_mode = cc_if.mode;
`ifdef CYCLE_COUNTER_DOWN_EN
            m_dir  = cc_if.dir;
`else
            m_dir  = 1'b0;
`endif
            m_cont  = m_dir ? m_lim : '0;
            m_state = 1;
            m_done  = 1'b0;
        end else if (m_state == 1 && en) begin
            if ((m_dir && m_cont == 0) || (!m_dir && m_cont == m_lim)) begin
                m_cont = m_dir ? m_lim : '0;
                m_rco  = 1'b1;
                if (m_mode) begin
                    m_state = 2;
                    m_done  = 1'b1;
                end
            end else if (m_dir) begin
                m_cont = m_cont - 1'b1;
            end else begin
                m_cont = m_cont + 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st, sp, en;
        rst          = 1'b1;
        cc_if.start  = 1'b0;
        cc_if.stop   = 1'b0;
        cc_if.enable = 1'b0;
        cc_if.mode   = 1'b0;
        cc_if.dir    = 1'b0;
        cc_if.limit  = '0;
        #12;
        check("rst.cont", 32'(cc_if.cont), 32'(0));
        check("rst.rco",  32'(cc_if.rco),  32'(0));
        check("rst.busy", 32'(cc_if.busy), 32'(0));
        check("rst.done", 32'(cc_if.done), 32'(0));
        rst = 1'b0;

        // free-running, limit 4: period 5
        cc_if.limit = W'(4);
        cc_if.mode  = 1'b0;
        cyc("fr_start", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc("fr", 0, 0, 1, W'(k % 5), (k % 5 == 0), 1, 0);
        end
        cyc("fr_stop", 0, 1, 1, W'(2), 0, 0, 0);

        // one-shot, limit 3, done sticky
        cc_if.limit = W'(3);
        cc_if.mode  = 1'b1;
        cyc("os_start", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc("os", 0, 0, 1, W'(k), 0, 1, 0);
        end
        cyc("os_end", 0, 0, 1, W'(0), 1, 0, 1);
        for (int k = 0; k < 10; k++) begin
            cyc("os_hold", 0, 0, 1, W'(0), 0, 0, 1);
        end
        cyc("os_restart", 1, 0, 1, W'(0), 0, 1, 0);
        cyc("os_stop", 0, 1, 1, W'(0), 0, 0, 0);

        // enable gap stretches the period
        cc_if.limit = W'(4);
        cc_if.mode  = 1'b0;
        cyc("gap_start", 1, 0, 1, W'(0), 0, 1, 0);
        cyc("gap", 0, 0, 1, W'(1), 0, 1, 0);
        cyc("gap", 0, 0, 1, W'(2), 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc("gap_hold", 0, 0, 0, W'(2), 0, 1, 0);
        end
        cyc("gap", 0, 0, 1, W'(3), 0, 1, 0);
        cyc("gap", 0, 0, 1, W'(4), 0, 1, 0);
        cyc("gap_wrap", 0, 0, 1, W'(0), 1, 1, 0);
        cyc("gap_stop", 0, 1, 1, W'(0), 0, 0, 0);

        // async reset mid-count, then start+stop together
        cc_if.limit = W'(7);
        cyc("ar_start", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc("ar", 0, 0, 1, W'(k), 0, 1, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("ar_rst.cont", 32'(cc_if.cont), 32'(0));
        check("ar_rst.rco",  32'(cc_if.rco),  32'(0));
        check("ar_rst.busy", 32'(cc_if.busy), 32'(0));
        check("ar_rst.done", 32'(cc_if.done), 32'(0));
        #1;
        rst = 1'b0;
        cyc("startstop", 1, 1, 1, W'(0), 0, 0, 0);
        cyc("ar_first_start", 1, 0, 1, W'(0), 0, 1, 0);
        cyc("ar_stop", 0, 1, 1, W'(0), 0, 0, 0);

        // limit 0, then restart in RUN while at terminal
        cc_if.limit = W'(0);
        cyc("l0_start", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc("l0", 0, 0, 1, W'(0), 1, 1, 0);
        end
        cc_if.limit = W'(6);
        cyc("l6_restart", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc("l6", 0, 0, 1, W'(k % 7), (k == 7), 1, 0);
        end
        cyc("l6_stop", 0, 1, 1, W'(0), 0, 0, 0);

        // dir=1 one-shot, limit 5
        cc_if.limit = W'(5);
        cc_if.mode  = 1'b1;
        cc_if.dir   = 1'b1;
`ifdef CYCLE_COUNTER_DOWN_EN
        cyc("dn_start", 1, 0, 1, W'(5), 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc("dn", 0, 0, 1, W'(5 - k), 0, 1, 0);
        end
        cyc("dn_end", 0, 0, 1, W'(5), 1, 0, 1);
        cyc("dn_stop", 0, 1, 1, W'(5), 0, 0, 0);
`else
        cyc("up_start", 1, 0, 1, W'(0), 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc("up", 0, 0, 1, W'(k), 0, 1, 0);
        end
        cyc("up_end", 0, 0, 1, W'(0), 1, 0, 1);
        cyc("up_stop", 0, 1, 1, W'(0), 0, 0, 0);
`endif
        cc_if.dir = 1'b0;

        // randomised traffic against the reference model
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_state = 0;
        m_cont  = '0;
        m_lim   = '0;
        m_mode  = 1'b0;
        m_dir   = 1'b0;
        m_rco   = 1'b0;
        m_done  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(7) == 0);
            sp = ($urandom_range(15) == 0);
            en = ($urandom_range(3) != 0);
            cc_if.limit = W'($urandom_range(15));
            cc_if.mode  = 1'($urandom_range(1));
            cc_if.dir   = 1'($urandom_range(1));
            model_step(st, sp, en);
            cyc("rnd", st, sp, en, m_cont, m_rco, (m_state == 1), m_done);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
